capt_sched: RTL and testbench
=============================

Name: capt_sched

Overview:
Packet-capture scheduler that sequences the capture write controller. It queues packet descriptors (begin/end addresses of packets in the source buffer) from the packet parser and issues them one at a time over the controller's start/ready handshake. It holds the capture-buffer configuration stable across each transfer, watchdogs each transfer, and keeps capture statistics and the host interrupt.

Parameters:
DESC_DEPTH, 8, descriptor queue depth in entries (power of 2, 2..64)
TIMEOUT_CYC, 4096, max cycles from start pulse to wr_ctrl_rdy before error
IRQ_PKTS, 16, interrupt after this many completed packets (0 = packet-count interrupt off)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
desc_valid  in  1  descriptor present
desc_ready  out  1  descriptor accepted when valid&ready
desc_begin  in  32  packet start address
desc_end  in  32  packet end address (exclusive)
control  in  32  [0] capture enable, [1] clear stats/error (level), [2] clear irq (pulse)
capt_buf_start  in  32  capture buffer base (host register)
capt_buf_size  in  32  capture buffer size in bytes (host register)
snaplen  in  16  truncation length (used only with feature)
wr_ctrl  out  1  one-cycle start pulse to write controller
pkt_begin  out  32  issued descriptor start, stable IDLE->done
pkt_end  out  32  issued descriptor end, stable IDLE->done
ctrl_out  out  32  control forwarded to write controller, latched at issue
buf_start_out  out  32  latched capt_buf_start
buf_size_out  out  32  latched capt_buf_size
wr_ctrl_rdy  in  1  one-cycle done pulse from write controller
capt_buf_wrap  in  1  wrap flag from write controller
pkt_count  out  32  completed packets
drop_count  out  32  descriptors dropped
err_timeout  out  1  sticky watchdog error
irq  out  1  level interrupt, cleared by control[2]

Behaviour:
- Reset (asynchronous, active-low): all outputs 0. Queue is empty. State is IDLE.
- Queue: a synchronous FIFO, DESC_DEPTH entries of {begin, end}. desc_ready = !full.
- Drop rules, each incrementing drop_count by 1:
  - A descriptor with desc_end <= desc_begin is discarded and not enqueued.
  - Every accepted descriptor while control[0]=0 is discarded.
  - desc_valid while full is not accepted and is not counted (producer stalls).
- Simultaneous push and pop on a full queue is allowed; occupancy is unchanged.
- FSM states IDLE, ISSUE, BUSY, GAP, HALT:
  - IDLE: if queue non-empty, control[0]=1 and err_timeout=0, then pop the head, latch pkt_begin/pkt_end/ctrl_out/buf_start_out/buf_size_out, and go to ISSUE.
  - ISSUE: wr_ctrl=1 for exactly this cycle. Clear the watchdog. Go to BUSY.
  - BUSY: the watchdog increments each cycle.
    - wr_ctrl_rdy=1: pkt_count++ and go to GAP.
    - Watchdog reaches TIMEOUT_CYC without wr_ctrl_rdy: set err_timeout and irq, then go to HALT.
  - GAP: one idle cycle, because the controller needs DONE->IDLE before a new start. Go to IDLE.
  - HALT: no issue. control[1]=1 clears err_timeout and goes to IDLE. The queue is kept.
- Minimum issue-to-issue spacing is 3 cycles plus the controller latency. Latched outputs must not change in ISSUE, BUSY or GAP, even if host registers change.
- wr_ctrl_rdy outside BUSY is ignored and not counted.
- control[0] deasserted in BUSY: the current transfer completes. No new issue follows.
- control[1]=1 zeroes pkt_count and drop_count. If it coincides with an increment, clear wins.
- Counters wrap at 2^32.
- irq: set on a capt_buf_wrap rising edge, on err_timeout set, or when pkt_count % IRQ_PKTS == 0 after an increment (IRQ_PKTS != 0). It is cleared by control[2]. If set and clear coincide, set wins.

Optional Feature:
Macro CAPT_SCHED_SNAPLEN_EN.
- Defined: at issue, if (end - begin) > snaplen and snaplen != 0, then pkt_end = begin + snaplen; otherwise pkt_end = end. The truncation compare is 32-bit with snaplen zero-extended.
- Not defined: snaplen is ignored and pkt_end = descriptor end.

Test Plan:
- Reset mid-BUSY with 3 queued: reset low for 2 cycles -> all outputs 0, queue empty, no wr_ctrl for 10 cycles after release.
- Enable=1, push {0x100, 0x140}, rdy 20 cycles after start -> one wr_ctrl pulse, pkt_begin=0x100, pkt_end=0x140 stable until GAP, pkt_count=1.
- Push 9 descriptors, DESC_DEPTH=8, rdy never asserted -> desc_ready=0 after 8 (one popped, so 9th accepted), err_timeout=1 exactly TIMEOUT_CYC cycles after start, irq=1, no further wr_ctrl. control[1] then resumes issue.
- Enable=0, push 3 valid descriptors plus 1 with end==begin -> drop_count=4, no wr_ctrl.
- IRQ_PKTS=2, four back-to-back packets, control[2] pulse after the 2nd -> irq high after the 2nd and 4th completions only. A capt_buf_wrap edge also sets irq.
- With CAPT_SCHED_SNAPLEN_EN, snaplen=64, push {0x1000, 0x1200} -> pkt_end=0x1040. snaplen=0 -> pkt_end=0x1200.

Source files
------------

// File: rtl/capt_sched.sv
// capt_sched: queues packet descriptors and issues them one at a time to the capture write controller.
// Optional snaplen truncation of pkt_end is built when CAPT_SCHED_SNAPLEN_EN is defined.
module capt_sched #(
  parameter int DESC_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int IRQ_PKTS    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_desc_valid,
  output logic        o_desc_ready,
  input  logic [31:0] i_desc_begin,
  input  logic [31:0] i_desc_end,
  input  logic [31:0] i_control,
  input  logic [31:0] i_capt_buf_start,
  input  logic [31:0] i_capt_buf_size,
  input  logic [15:0] i_snaplen,
  output logic        o_wr_ctrl,
  output logic [31:0] o_pkt_begin,
  output logic [31:0] o_pkt_end,
  output logic [31:0] o_ctrl_out,
  output logic [31:0] o_buf_start_out,
  output logic [31:0] o_buf_size_out,
  input  logic        i_wr_ctrl_rdy,
  input  logic        i_capt_buf_wrap,
  output logic [31:0] o_pkt_count,
  output logic [31:0] o_drop_count,
  output logic        o_err_timeout,
  output logic        o_irq
);
  // state | meaning
  // IDLE  | wait for a queued descriptor while enabled and error-free
  // ISSUE | start pulse on wr_ctrl, watchdog loaded
  // BUSY  | transfer in flight, watchdog counting down
  // GAP   | one dead cycle so the controller returns DONE->IDLE
  // HALT  | watchdog expired, waits for control[1]
  localparam int AW = $clog2(DESC_DEPTH);
  localparam int IRQ_DIV = (IRQ_PKTS == 0) ? 1 : IRQ_PKTS;
  localparam logic [31:0] WD_LOAD = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_GAP, S_HALT} state_t;

  state_t        r_state;
  logic [63:0]   r_mem [DESC_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_desc_ready;
  logic [31:0]   r_wd;
  logic          r_wr_ctrl, r_err, r_irq, r_wrap_d;
  logic [31:0]   r_pkt_begin, r_pkt_end, r_ctrl_out, r_buf_start, r_buf_size;
  logic [31:0]   r_pkt_count, r_drop_count;

  logic          w_push, w_keep, w_pop, w_empty, w_done, w_timeout, w_clr_stats;
  logic          w_irq_cnt_hit, w_irq_set;
  logic [AW:0]   w_count_nxt;
  logic [31:0]   w_head_begin, w_head_end, w_issue_end, w_pkt_inc;

  assign w_empty     = (r_count == '0);
  assign w_push      = i_desc_valid && r_desc_ready;
  assign w_keep      = w_push && i_control[0] && (i_desc_end > i_desc_begin);
  assign w_pop       = (r_state == S_IDLE) && !w_empty && i_control[0] && !r_err;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_keep} - {{AW{1'b0}}, w_pop};
  assign w_head_begin = r_mem[r_rd_ptr][63:32];
  assign w_head_end   = r_mem[r_rd_ptr][31:0];

`ifdef CAPT_SCHED_SNAPLEN_EN
  logic [31:0] w_len;
  assign w_len       = w_head_end - w_head_begin;
  assign w_issue_end = ((i_snaplen != 16'd0) && (w_len > {16'd0, i_snaplen}))
                       ? (w_head_begin + {16'd0, i_snaplen}) : w_head_end;
`else
  logic w_snaplen_unused;
  assign w_snaplen_unused = ^i_snaplen;
  assign w_issue_end      = w_head_end;
`endif

  assign w_done        = (r_state == S_BUSY) && i_wr_ctrl_rdy;
  assign w_timeout     = (r_state == S_BUSY) && !i_wr_ctrl_rdy && (r_wd <= 32'd1);
  assign w_clr_stats   = i_control[1];
  assign w_pkt_inc     = r_pkt_count + 32'd1;
  assign w_irq_cnt_hit = (IRQ_PKTS != 0) && w_done && !w_clr_stats &&
                         ((w_pkt_inc % 32'(IRQ_DIV)) == 32'd0);
  assign w_irq_set     = w_timeout || w_irq_cnt_hit || (i_capt_buf_wrap && !r_wrap_d);

  always_ff @(posedge i_clk) begin
    if (w_keep) r_mem[r_wr_ptr] <= {i_desc_begin, i_desc_end};
  end

  // Ready is registered so it reads 0 during reset and tracks !full afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_desc_ready <= 1'b0;
    end else begin
      if (w_keep) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count      <= w_count_nxt;
      r_desc_ready <= (w_count_nxt != (AW+1)'(DESC_DEPTH));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ctrl   <= 1'b0;
      r_wd        <= '0;
      r_err       <= 1'b0;
      r_pkt_begin <= '0;
      r_pkt_end   <= '0;
      r_ctrl_out  <= '0;
      r_buf_start <= '0;
      r_buf_size  <= '0;
    end else begin
      r_wr_ctrl <= 1'b0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_pkt_begin <= w_head_begin;
          r_pkt_end   <= w_issue_end;
          r_ctrl_out  <= i_control;
          r_buf_start <= i_capt_buf_start;
          r_buf_size  <= i_capt_buf_size;
          r_wr_ctrl   <= 1'b1;
          r_state     <= S_ISSUE;
        end
        S_ISSUE: begin
          r_wd    <= WD_LOAD;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (i_wr_ctrl_rdy) begin
            r_state <= S_GAP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wd <= r_wd - 32'd1;
          end
        end
        S_GAP: r_state <= S_IDLE;
        S_HALT: if (i_control[1]) begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_irq        <= 1'b0;
      r_wrap_d     <= 1'b0;
    end else begin
      r_wrap_d <= i_capt_buf_wrap;
      if (w_clr_stats) begin
        r_pkt_count  <= '0;
        r_drop_count <= '0;
      end else begin
        if (w_done)            r_pkt_count  <= w_pkt_inc;
        if (w_push && !w_keep) r_drop_count <= r_drop_count + 32'd1;
      end
      if (w_irq_set)         r_irq <= 1'b1;
      else if (i_control[2]) r_irq <= 1'b0;
    end
  end

  assign o_desc_ready    = r_desc_ready;
  assign o_wr_ctrl       = r_wr_ctrl;
  assign o_pkt_begin     = r_pkt_begin;
  assign o_pkt_end       = r_pkt_end;
  assign o_ctrl_out      = r_ctrl_out;
  assign o_buf_start_out = r_buf_start;
  assign o_buf_size_out  = r_buf_size;
  assign o_pkt_count     = r_pkt_count;
  assign o_drop_count    = r_drop_count;
  assign o_err_timeout   = r_err;
  assign o_irq           = r_irq;

endmodule

// File: tb/tb_capt_sched.sv
// tb_capt_sched: directed bench for capt_sched (drop-rule table plus hand sequences).
module tb_capt_sched;
  localparam int DEPTH = 8;
  localparam int TOUT  = 64;
  localparam int IRQN  = 2;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_desc_valid = 1'b0;
  logic [31:0] i_desc_begin = '0, i_desc_end = '0, i_control = '0;
  logic [31:0] i_capt_buf_start = '0, i_capt_buf_size = '0;
  logic [15:0] i_snaplen = '0;
  logic        i_wr_ctrl_rdy = 1'b0;
  logic        i_capt_buf_wrap = 1'b0;
  logic        o_desc_ready, o_wr_ctrl, o_err_timeout, o_irq;
  logic [31:0] o_pkt_begin, o_pkt_end, o_ctrl_out, o_buf_start_out, o_buf_size_out;
  logic [31:0] o_pkt_count, o_drop_count;

  capt_sched #(.DESC_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT), .IRQ_PKTS(IRQN)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
    .i_desc_begin(i_desc_begin), .i_desc_end(i_desc_end), .i_control(i_control),
    .i_capt_buf_start(i_capt_buf_start), .i_capt_buf_size(i_capt_buf_size), .i_snaplen(i_snaplen),
    .o_wr_ctrl(o_wr_ctrl), .o_pkt_begin(o_pkt_begin), .o_pkt_end(o_pkt_end), .o_ctrl_out(o_ctrl_out),
    .o_buf_start_out(o_buf_start_out), .o_buf_size_out(o_buf_size_out), .i_wr_ctrl_rdy(i_wr_ctrl_rdy),
    .i_capt_buf_wrap(i_capt_buf_wrap), .o_pkt_count(o_pkt_count), .o_drop_count(o_drop_count),
    .o_err_timeout(o_err_timeout), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  int cyc = 0, wr_cnt = 0, wr_cyc = 0, rdy_lat = 0, lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (o_wr_ctrl === 1'b1) begin
    wr_cnt = wr_cnt + 1;
    wr_cyc = cyc;
  end

  // Write-controller model: answers each start pulse with a done pulse rdy_lat cycles later.
  always begin
    @(negedge clk);
    if (o_wr_ctrl === 1'b1 && rdy_lat > 0) begin
      lat = rdy_lat;
      repeat (lat) @(negedge clk);
      i_wr_ctrl_rdy = 1'b1;
      @(negedge clk);
      i_wr_ctrl_rdy = 1'b0;
    end
  end

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] b;
    logic [31:0] e;
    logic [31:0] exp_drop;
  } drop_vec_t;
  drop_vec_t dv[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] e);
    int  n;
    logic rdy_now;
    n = 0;
    i_desc_valid = 1'b1;
    i_desc_begin = b;
    i_desc_end   = e;
    do begin
      rdy_now = o_desc_ready;
      tick();
      n++;
    end while (!rdy_now && n < 50);
    i_desc_valid = 1'b0;
    if (!rdy_now) chk("push_handshake", 32'(rdy_now), 1);
  endtask

  task automatic wait_wr(input int budget, input string nm);
    int n;
    n = 0;
    while (o_wr_ctrl !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 32'(o_wr_ctrl), 1);
  endtask

  task automatic wait_pkts(input logic [31:0] k, input int budget, output int n);
    n = 0;
    while (o_pkt_count !== k && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_desc_ready), 0);
    chk({tag, "_wr_ctrl"}, 32'(o_wr_ctrl), 0);
    chk({tag, "_pkt_begin"}, o_pkt_begin, 0);
    chk({tag, "_pkt_end"}, o_pkt_end, 0);
    chk({tag, "_ctrl_out"}, o_ctrl_out, 0);
    chk({tag, "_buf_start"}, o_buf_start_out, 0);
    chk({tag, "_buf_size"}, o_buf_size_out, 0);
    chk({tag, "_pkt_count"}, o_pkt_count, 0);
    chk({tag, "_drop_count"}, o_drop_count, 0);
    chk({tag, "_err"}, 32'(o_err_timeout), 0);
    chk({tag, "_irq"}, 32'(o_irq), 0);
  endtask

  initial begin
    int n, wr_before;
    logic [31:0] exp_end;

    dv[0] = '{32'h0, 32'h200, 32'h240, 32'd1};
    dv[1] = '{32'h0, 32'h300, 32'h310, 32'd2};
    dv[2] = '{32'h0, 32'h400, 32'h500, 32'd3};
    dv[3] = '{32'h0, 32'h500, 32'h500, 32'd4};
    dv[4] = '{32'h1, 32'h600, 32'h600, 32'd5};
    dv[5] = '{32'h1, 32'h700, 32'h6FF, 32'd6};

    // Power-on reset
    repeat (2) tick();
    chk_all_zero("por");
    i_rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(o_desc_ready), 1);

    // Single packet, controller latency 20
    i_control = 32'h1;
    i_capt_buf_start = 32'hA000;
    i_capt_buf_size  = 32'h800;
    rdy_lat = 20;
    push(32'h100, 32'h140);
    wait_wr(5, "a_wr_ctrl");
    chk("a_pkt_begin", o_pkt_begin, 32'h100);
    chk("a_pkt_end", o_pkt_end, 32'h140);
    chk("a_ctrl_out", o_ctrl_out, 32'h1);
    chk("a_buf_size", o_buf_size_out, 32'h800);
    i_capt_buf_start = 32'hB000;
    tick();
    chk("a_pulse_width", 32'(o_wr_ctrl), 0);
    n = 1;
    while (o_pkt_count !== 32'd1 && n < 60) begin
      tick();
      n++;
    end
    chk("a_done_latency", 32'(n), 21);
    chk("a_pkt_count", o_pkt_count, 1);
    chk("a_begin_stable", o_pkt_begin, 32'h100);
    chk("a_buf_start_held", o_buf_start_out, 32'hA000);
    chk("a_irq_low", 32'(o_irq), 0);

    // Drop rules, table driven
    foreach (dv[i]) begin
      i_control = dv[i].ctrl;
      push(dv[i].b, dv[i].e);
      chk($sformatf("drop_vec%0d", i), o_drop_count, dv[i].exp_drop);
    end
    repeat (5) tick();
    chk("drop_no_issue", 32'(wr_cnt), 1);

    i_control = 32'h2;
    tick();
    i_control = 32'h1;
    chk("clr_pkt_count", o_pkt_count, 0);
    chk("clr_drop_count", o_drop_count, 0);

    // Packet-count interrupt with a clear after the 2nd completion
    rdy_lat = 3;
    for (int i = 0; i < 4; i++) push(32'h4000 + 32'(i) * 32'h100, 32'h4040 + 32'(i) * 32'h100);
    for (int k = 1; k <= 4; k++) begin
      wait_pkts(32'(k), 60, n);
      chk($sformatf("irq_pkt%0d_count", k), o_pkt_count, 32'(k));
      chk($sformatf("irq_pkt%0d_level", k), 32'(o_irq), 32'((k % 2) == 0));
      if (k == 2) begin
        i_control = 32'h5;
        tick();
        i_control = 32'h1;
        chk("irq_cleared", 32'(o_irq), 0);
      end
    end

    // Wrap edge sets irq once
    i_control = 32'h5;
    tick();
    i_control = 32'h1;
    chk("wrap_pre", 32'(o_irq), 0);
    i_capt_buf_wrap = 1'b1;
    tick();
    chk("wrap_edge_irq", 32'(o_irq), 1);
    i_control = 32'h5;
    tick();
    i_control = 32'h1;
    tick();
    chk("wrap_level_no_irq", 32'(o_irq), 0);
    i_capt_buf_wrap = 1'b0;
    i_control = 32'h3;
    tick();
    i_control = 32'h1;

    // Full queue and watchdog timeout
    rdy_lat = 0;
    wr_before = wr_cnt;
    for (int i = 0; i < 9; i++) push(32'h2000 + 32'(i) * 32'h100, 32'h2080 + 32'(i) * 32'h100);
    chk("full_ready_low", 32'(o_desc_ready), 0);
    i_desc_valid = 1'b1;
    i_desc_begin = 32'h9000;
    i_desc_end   = 32'h9080;
    repeat (3) tick();
    chk("full_stall_ready", 32'(o_desc_ready), 0);
    chk("full_stall_no_drop", o_drop_count, 0);
    i_desc_valid = 1'b0;
    n = 0;
    while (o_err_timeout !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("to_err", 32'(o_err_timeout), 1);
    chk("to_latency", 32'(cyc - wr_cyc), 32'(TOUT));
    chk("to_irq", 32'(o_irq), 1);
    repeat (10) tick();
    chk("to_halt_no_issue", 32'(wr_cnt - wr_before), 1);
    chk("to_queue_kept", 32'(o_desc_ready), 0);
    rdy_lat = 2;
    wr_before = wr_cnt;
    i_control = 32'h3;
    tick();
    i_control = 32'h1;
    chk("resume_err_clr", 32'(o_err_timeout), 0);
    wait_wr(10, "resume_wr_ctrl");
    chk("resume_begin", o_pkt_begin, 32'h2100);
    wait_pkts(32'd8, 200, n);
    repeat (6) tick();
    chk("resume_drained", o_pkt_count, 8);
    chk("resume_issues", 32'(wr_cnt - wr_before), 8);
    chk("resume_ready", 32'(o_desc_ready), 1);

    // Snap length
    i_snaplen = 16'd64;
`ifdef CAPT_SCHED_SNAPLEN_EN
    exp_end = 32'h1040;
`else
    exp_end = 32'h1200;
`endif
    push(32'h1000, 32'h1200);
    wait_wr(5, "snap64_wr");
    chk("snap64_end", o_pkt_end, exp_end);
    repeat (6) tick();
    i_snaplen = 16'd0;
    push(32'h1000, 32'h1200);
    wait_wr(5, "snap0_wr");
    chk("snap0_end", o_pkt_end, 32'h1200);
    repeat (6) tick();
    i_snaplen = 16'h200;
    push(32'h1000, 32'h1200);
    wait_wr(5, "snapeq_wr");
    chk("snapeq_end", o_pkt_end, 32'h1200);
    repeat (6) tick();
    i_snaplen = 16'h1FF;
`ifdef CAPT_SCHED_SNAPLEN_EN
    exp_end = 32'h11FF;
`else
    exp_end = 32'h1200;
`endif
    push(32'h1000, 32'h1200);
    wait_wr(5, "snap1ff_wr");
    chk("snap1ff_end", o_pkt_end, exp_end);
    repeat (6) tick();

    // Asynchronous reset mid-BUSY with three queued
    rdy_lat = 0;
    for (int i = 0; i < 4; i++) push(32'h3000 + 32'(i) * 32'h100, 32'h3040 + 32'(i) * 32'h100);
    repeat (4) tick();
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) tick();
    i_rst_n = 1'b1;
    wr_before = wr_cnt;
    repeat (10) tick();
    chk("post_rst_no_issue", 32'(wr_cnt - wr_before), 0);
    chk("post_rst_ready", 32'(o_desc_ready), 1);
    chk("post_rst_pkt_begin", o_pkt_begin, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
